// File: rtl/bpu_bht_pkg.sv
// Shared constants for the bpu_bht branch predictor: default PC width,
// 2-bit counter encodings and init/run FSM state encodings.
package bpu_bht_pkg;

    localparam int BPU_PC_WIDTH = 32;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/bht_ctr2.sv
// Combinational 2-bit saturating counter update: moves toward ST on taken,
// toward SNT on not-taken, and never wraps.
module bht_ctr2
    import bpu_bht_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic t);
        if (t) begin
            return (c == CTR_ST) ? CTR_ST : c + 2'd1;
        end
        return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
    endfunction

    assign ctr_nxt = sat_update(ctr, taken);

endmodule

// File: rtl/bpu_bht.sv
// Direct-mapped branch predictor: 2-bit counter table plus BTB with an init FSM
// that clears the table after reset/flush. Optional counters via BPU_STATS_EN.
module bpu_bht
    import bpu_bht_pkg::*;
#(
    parameter int PC_WIDTH   = BPU_PC_WIDTH,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = PC_WIDTH - INDEX_BITS - 2
) (
    input  logic                clk_i,
    input  logic                rst,
    input  logic                flush_i,
    input  logic [PC_WIDTH-1:0] F_PC_i,
    output logic                F_pred_taken_o,
    output logic [PC_WIDTH-1:0] F_pred_target_o,
    output logic                F_pred_hit_o,
    input  logic                ED_train_vaild_i,
    input  logic [PC_WIDTH-1:0] ED_PC_i,
    input  logic                ED_train_taken_i,
    input  logic [PC_WIDTH-1:0] ED_jmp_i,
    input  logic                ED_train_predict_i,
    output logic                busy_o
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]         stat_branches_o,
    output logic [31:0]         stat_mispredict_o
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    // Table storage has no reset so it can map onto RAM; the FSM clears it.
    logic                valid_mem [ENTRIES];
    logic [TAG_BITS-1:0] tag_mem   [ENTRIES];
    logic [PC_WIDTH-1:0] tgt_mem   [ENTRIES];
    logic [1:0]          ctr_mem   [ENTRIES];

    logic [0:0]            state_q;
    logic [INDEX_BITS-1:0] clr_cnt_q;
    logic                  run;

    logic [INDEX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0]   f_tag;
    logic                  f_hit;
    logic                  f_taken;

    logic [INDEX_BITS-1:0] e_idx;
    logic [TAG_BITS-1:0]   e_tag;
    logic                  e_hit;
    logic [1:0]            e_ctr_nxt;
    logic                  train_en;

    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_idx;
    logic                  wr_valid;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [PC_WIDTH-1:0]   wr_tgt;
    logic [1:0]            wr_ctr;

    logic                  unused_pc_bits;

    assign run    = (state_q == ST_RUN);
    assign busy_o = ~run;

    // Lookup: purely combinational, forced to not-taken while clearing.
    assign f_idx   = F_PC_i[INDEX_BITS+1:2];
    assign f_tag   = F_PC_i[PC_WIDTH-1:INDEX_BITS+2];
    assign f_hit   = run & valid_mem[f_idx] & (tag_mem[f_idx] == f_tag);
    assign f_taken = f_hit & ctr_mem[f_idx][1];

    assign F_pred_hit_o    = f_hit;
    assign F_pred_taken_o  = f_taken;
    assign F_pred_target_o = f_taken ? tgt_mem[f_idx] : F_PC_i + PC_WIDTH'(4);

    // Training lookup on the resolved branch.
    assign e_idx    = ED_PC_i[INDEX_BITS+1:2];
    assign e_tag    = ED_PC_i[PC_WIDTH-1:INDEX_BITS+2];
    assign e_hit    = valid_mem[e_idx] & (tag_mem[e_idx] == e_tag);
    assign train_en = run & ED_train_vaild_i & ~flush_i;

    bht_ctr2 u_ctr2 (
        .ctr     (ctr_mem[e_idx]),
        .taken   (ED_train_taken_i),
        .ctr_nxt (e_ctr_nxt)
    );

    // Single write port shared by the clear sweep and training; flush wins.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = e_idx;
        wr_valid = 1'b1;
        wr_tag   = e_tag;
        wr_tgt   = tgt_mem[e_idx];
        wr_ctr   = e_ctr_nxt;
        if (flush_i) begin
            wr_en = 1'b0;
        end else if (!run) begin
            wr_en    = 1'b1;
            wr_idx   = clr_cnt_q;
            wr_valid = 1'b0;
            wr_tag   = '0;
            wr_tgt   = '0;
            wr_ctr   = CTR_WNT;
        end else if (train_en) begin
            if (e_hit) begin
                wr_en = 1'b1;
                if (ED_train_taken_i) begin
                    wr_tgt = ED_jmp_i;
                end
            end else if (ED_train_taken_i) begin
                wr_en  = 1'b1;
                wr_tgt = ED_jmp_i;
                wr_ctr = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            valid_mem[wr_idx] <= wr_valid;
            tag_mem[wr_idx]   <= wr_tag;
            tgt_mem[wr_idx]   <= wr_tgt;
            ctr_mem[wr_idx]   <= wr_ctr;
        end
    end

    // Init FSM: sweep every entry once, then run until the next flush.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else if (flush_i) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else if (state_q == ST_INIT) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
                state_q <= ST_RUN;
            end
        end
    end

`ifdef BPU_STATS_EN
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            stat_branches_o   <= '0;
            stat_mispredict_o <= '0;
        end else if (flush_i) begin
            stat_branches_o   <= '0;
            stat_mispredict_o <= '0;
        end else if (train_en) begin
            stat_branches_o <= stat_branches_o + 32'd1;
            if (ED_train_predict_i != ED_train_taken_i) begin
                stat_mispredict_o <= stat_mispredict_o + 32'd1;
            end
        end
    end
`endif

    assign unused_pc_bits = ^{F_PC_i[1:0], ED_PC_i[1:0], ED_train_predict_i};

endmodule

// File: tb/tb_bpu_bht.sv
// Self-checking bench for bpu_bht: scoreboarded lookups against expected
// predictions, init/flush timing and (with BPU_STATS_EN) the statistics counters.
module tb_bpu_bht;

    logic        clk_i = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [31:0] F_PC_i;
    logic        F_pred_taken_o;
    logic [31:0] F_pred_target_o;
    logic        F_pred_hit_o;
    logic        ED_train_vaild_i;
    logic [31:0] ED_PC_i;
    logic        ED_train_taken_i;
    logic [31:0] ED_jmp_i;
    logic        ED_train_predict_i;
    logic        busy_o;
`ifdef BPU_STATS_EN
    logic [31:0] stat_branches_o;
    logic [31:0] stat_mispredict_o;
`endif

    always #5 clk_i = ~clk_i;

    bpu_bht dut (
        .clk_i              (clk_i),
        .rst                (rst),
        .flush_i            (flush_i),
        .F_PC_i             (F_PC_i),
        .F_pred_taken_o     (F_pred_taken_o),
        .F_pred_target_o    (F_pred_target_o),
        .F_pred_hit_o       (F_pred_hit_o),
        .ED_train_vaild_i   (ED_train_vaild_i),
        .ED_PC_i            (ED_PC_i),
        .ED_train_taken_i   (ED_train_taken_i),
        .ED_jmp_i           (ED_jmp_i),
        .ED_train_predict_i (ED_train_predict_i),
        .busy_o             (busy_o)
`ifdef BPU_STATS_EN
        ,
        .stat_branches_o    (stat_branches_o),
        .stat_mispredict_o  (stat_mispredict_o)
`endif
    );

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_br   = 0;
    int   exp_mis  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                          input logic taken, input logic [31:0] tgt);
        exp_t e;
        F_PC_i = pc;
        sb.push_back('{hit: hit, taken: taken, tgt: tgt});
        #1;
        e = sb.pop_front();
        check({tag, "_hit"}, 64'(F_pred_hit_o), 64'(e.hit));
        check({tag, "_taken"}, 64'(F_pred_taken_o), 64'(e.taken));
        check({tag, "_tgt"}, 64'(F_pred_target_o), 64'(e.tgt));
    endtask

    task automatic train_drive(input logic [31:0] pc, input logic taken,
                               input logic [31:0] jmp, input logic pred);
        ED_PC_i            = pc;
        ED_train_taken_i   = taken;
        ED_jmp_i           = jmp;
        ED_train_predict_i = pred;
        ED_train_vaild_i   = 1'b1;
        exp_br++;
        if (pred != taken) exp_mis++;
    endtask

    task automatic train_done();
        @(negedge clk_i);
        ED_train_vaild_i = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken,
                         input logic [31:0] jmp, input logic pred);
        train_drive(pc, taken, jmp, pred);
        train_done();
    endtask

    // Counts busy cycles from now; injects one strobe mid-clear that must be dropped.
    task automatic count_busy(input string tag, input logic [31:0] drop_pc);
        int cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy_o) break;
            cnt++;
            ED_train_vaild_i = (i == 10);
            if (i == 10) begin
                ED_PC_i          = drop_pc;
                ED_train_taken_i = 1'b1;
                ED_jmp_i         = 32'h600;
            end
            @(negedge clk_i);
        end
        ED_train_vaild_i = 1'b0;
        check(tag, 64'(cnt), 64'd64);
    endtask

    task automatic pulse_flush_with_strobe(input logic [31:0] pc);
        @(negedge clk_i);
        flush_i            = 1'b1;
        ED_PC_i            = pc;
        ED_train_taken_i   = 1'b1;
        ED_jmp_i           = 32'h400;
        ED_train_predict_i = 1'b0;
        ED_train_vaild_i   = 1'b1;
        @(negedge clk_i);
        flush_i          = 1'b0;
        ED_train_vaild_i = 1'b0;
        exp_br           = 0;
        exp_mis          = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst                = 1'b1;
        flush_i            = 1'b0;
        F_PC_i             = 32'h100;
        ED_train_vaild_i   = 1'b0;
        ED_PC_i            = '0;
        ED_train_taken_i   = 1'b0;
        ED_jmp_i           = '0;
        ED_train_predict_i = 1'b0;

        repeat (3) @(negedge clk_i);
        check("rst_busy", 64'(busy_o), 64'd1);
        lookup("rst", 32'h100, 1'b0, 1'b0, 32'h104);

        @(negedge clk_i);
        rst = 1'b0;
        lookup("init", 32'h100, 1'b0, 1'b0, 32'h104);
        count_busy("busy_len_rst", 32'h0);
        check("run_busy", 64'(busy_o), 64'd0);
        lookup("drop_rst", 32'h0, 1'b0, 1'b0, 32'h4);

        train_drive(32'h100, 1'b1, 32'h200, 1'b0);
        lookup("rdw", 32'h100, 1'b0, 1'b0, 32'h104);
        train_done();
        lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

        train(32'h100, 1'b0, 32'h0, 1'b1);
        lookup("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        lookup("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        lookup("nt3", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 1'b1, 32'h240, 1'b0);
        lookup("up1", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 1'b1, 32'h280, 1'b0);
        lookup("up2", 32'h100, 1'b1, 1'b1, 32'h280);
        train(32'h100, 1'b1, 32'h2c0, 1'b1);
        train(32'h100, 1'b1, 32'h2c0, 1'b1);
        train(32'h100, 1'b0, 32'h0, 1'b1);
        lookup("sat_hi", 32'h100, 1'b1, 1'b1, 32'h2c0);

        train(32'h200, 1'b1, 32'h300, 1'b0);
        lookup("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        lookup("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        lookup("ntmiss_keep", 32'h200, 1'b1, 1'b1, 32'h300);
        lookup("ntmiss_noalloc", 32'h100, 1'b0, 1'b0, 32'h104);
        @(negedge clk_i);
        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

`ifdef BPU_STATS_EN
        check("stat_br_run", 64'(stat_branches_o), 64'(exp_br));
        check("stat_mis_run", 64'(stat_mispredict_o), 64'(exp_mis));
`endif

        pulse_flush_with_strobe(32'h300);
`ifdef BPU_STATS_EN
        check("stat_br_flush", 64'(stat_branches_o), 64'd0);
        check("stat_mis_flush", 64'(stat_mispredict_o), 64'd0);
`endif
        count_busy("busy_len_flush", 32'h0);
        lookup("fl_100", 32'h100, 1'b0, 1'b0, 32'h104);
        lookup("fl_200", 32'h200, 1'b0, 1'b0, 32'h204);
        @(negedge clk_i);
        lookup("fl_300", 32'h300, 1'b0, 1'b0, 32'h304);
        lookup("fl_drop", 32'h0, 1'b0, 1'b0, 32'h4);

        for (int i = 0; i < 10; i++) begin
            logic tk;
            tk = logic'(i % 2);
            train(32'h400 + 32'(i * 4), tk, 32'h800 + 32'(i * 4), (i < 3) ? ~tk : tk);
        end
        lookup("alloc2", 32'h404, 1'b1, 1'b1, 32'h804);
        lookup("noalloc2", 32'h408, 1'b0, 1'b0, 32'h40c);

`ifdef BPU_STATS_EN
        check("stat_br_10", 64'(stat_branches_o), 64'(exp_br));
        check("stat_mis_3", 64'(stat_mispredict_o), 64'(exp_mis));
        pulse_flush_with_strobe(32'h500);
        check("stat_br_clr", 64'(stat_branches_o), 64'd0);
        check("stat_mis_clr", 64'(stat_mispredict_o), 64'd0);
        count_busy("busy_len_flush2", 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
